riscv_boot_sequencer: RTL and testbench
=======================================

Name: riscv_boot_sequencer

Overview:
- Controller that boots and runs the 8-bit RISC-V pipeline core.
- Holds the core in reset and clears instruction memory. Streams a program from a valid/ready loader port into instruction memory (address + data + write strobe), then releases the core for a bounded cycle budget.
- Sits between the host/testbench loader and the core's reset, instruction-memory reset, instruction write address and instruction write data inputs.

Parameters:
- PC_SIZE, 10, width of the instruction-memory write address (matches core PC width).
- ADDR_STEP, 4, address increment per loaded word (byte-addressed PC).
- CLEAR_CYCLES, 2, number of cycles imem_reset is held high during the clear phase (min 1).
- MAX_WORDS, 256, maximum words accepted per load before overflow error.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin boot sequence; sampled only in IDLE.
- abort  in  1  return to IDLE from any non-IDLE state.
- run_limit  in  16  core run budget in cycles; 0 = run until abort.
- load_valid  in  1  loader word valid.
- load_data  in  32  loader instruction word.
- load_last  in  1  qualifies final word of the program.
- load_ready  out  1  sequencer accepts a word this cycle.
- core_reset  out  1  drives core reset.
- imem_reset  out  1  drives core instruction-memory reset.
- imem_we  out  1  instruction write strobe.
- imem_addr  out  PC_SIZE  instruction write address.
- imem_data  out  32  instruction write data.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- error  out  1  sticky overflow flag; cleared on next start.
- word_count  out  PC_SIZE+1  words written in last load.
- cycle_count  out  16  core cycles elapsed in RUN.

Behaviour:
- Clock is clock. Reset is synchronous and active-high, named reset.
- Reset values:
  - core_reset=1; all other outputs 0; state IDLE; address counter 0.
- States: IDLE, CLEAR, LOAD, SETTLE, RUN, DONE.
- IDLE:
  - core_reset=1, load_ready=0.
  - start=1 → CLEAR; clears error, word_count, cycle_count and the address counter.
- CLEAR:
  - imem_reset=1 for exactly CLEAR_CYCLES cycles (internal counter), then → LOAD.
  - core_reset stays 1.
- LOAD:
  - load_ready=1 while the word counter is below MAX_WORDS.
  - Transfer occurs when load_valid & load_ready.
  - Cycle after a transfer: imem_we=1 for one cycle, with imem_addr = current address and imem_data = load_data (registered, 1-cycle latency). Address then advances by ADDR_STEP, wrapping modulo 2^PC_SIZE; word_count increments.
  - Back-to-back transfers allowed: one word per cycle.
  - Transfer with load_last=1 → SETTLE; load_ready drops the same cycle the last word is accepted.
  - If MAX_WORDS words are accepted without load_last: error=1, → DONE (core never released).
- SETTLE:
  - One cycle, core_reset=1, which covers the final imem_we pulse. Then → RUN.
- RUN:
  - core_reset=0; cycle_count increments each cycle, saturating at 0xFFFF.
  - If run_limit≠0 and cycle_count reaches run_limit-1 in this cycle → DONE, so the core runs exactly run_limit cycles.
- DONE:
  - core_reset=1, done=1; outputs hold.
  - start=1 → CLEAR (new boot); otherwise stay.
- abort:
  - Highest priority after reset; any state → IDLE next cycle.
  - core_reset=1, imem_we and imem_reset forced 0 that cycle.
  - A pending registered write is dropped.
- start is ignored outside IDLE/DONE. load_valid is ignored outside LOAD.

Optional Feature:
- Macro: BOOT_SEQ_CHECKSUM_EN.
- Defined:
  - Extra output checksum[31:0], reset to 0 and cleared on start.
  - Each accepted word updates it as checksum = {checksum[30:0],checksum[31]} ^ load_data, i.e. rotate-left-1 then XOR.
  - Valid in SETTLE/RUN/DONE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then idle 5 cycles → core_reset=1, busy=0, done=0, imem_we never asserted.
- start; 3 words 0x00000013, 0x00100093, 0x00208133 (last on 3rd), run_limit=10:
  - imem_reset high exactly 2 cycles.
  - imem_we pulses with addr 0, 4, 8 and matching data.
  - word_count=3; core_reset low exactly 10 cycles; then done=1, cycle_count=10.
- load_valid toggled 1/0 each cycle with 4 words → exactly 4 imem_we pulses, addresses 0, 4, 8, 12, no duplicates.
- MAX_WORDS=4, 4 words without load_last → error=1, done=1, core_reset never deasserted, load_ready=0 after the 4th accept.
- abort asserted mid-LOAD after 2 words, and again in RUN with run_limit=0 → IDLE next cycle, core_reset=1, no further imem_we. A subsequent start clears error/counts and restarts at addr 0.
- With BOOT_SEQ_CHECKSUM_EN, words 0x00000001, 0x80000000 → checksum 0x80000002.

Source files
------------

// File: rtl/riscv_boot_sequencer.sv
// riscv_boot_sequencer
//   Boot controller for the 8-bit RISC-V pipeline core. It works through these
//   phases in order:
//     1. Hold the core in reset.
//     2. Pulse the instruction-memory reset for CLEAR_CYCLES cycles.
//     3. Stream a program from a valid/ready loader port into instruction
//        memory.
//     4. Release the core for run_limit cycles, or until abort when
//        run_limit is 0.
//
// Optional feature (macro BOOT_SEQ_CHECKSUM_EN):
//   Adds a checksum output. Each accepted word updates it as
//   rotate-left-1, then XOR with the word.
//
// Ports:
//   clock, reset        rising-edge clock; synchronous active-high reset
//   start, abort        begin a boot (from IDLE/DONE); return to IDLE
//   run_limit           core run budget in cycles (0 = unbounded)
//   load_valid/data/last, load_ready
//                       loader stream handshake
//   core_reset, imem_reset
//                       resets driven into the core
//   imem_we/addr/data   instruction-memory write port
//                       (one cycle after accept)
//   busy, done, error   status flags; error is sticky until the next start
//   word_count          words written in the last load
//   cycle_count         core cycles elapsed in RUN (saturating)
//   checksum            rolling program checksum (BOOT_SEQ_CHECKSUM_EN only)
module riscv_boot_sequencer #(
  parameter int unsigned PC_SIZE      = 10,
  parameter int unsigned ADDR_STEP    = 4,
  parameter int unsigned CLEAR_CYCLES = 2,
  parameter int unsigned MAX_WORDS    = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [15:0]        run_limit,
  input  logic               load_valid,
  input  logic [31:0]        load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               core_reset,
  output logic               imem_reset,
  output logic               imem_we,
  output logic [PC_SIZE-1:0] imem_addr,
  output logic [31:0]        imem_data,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [PC_SIZE:0]   word_count,
  output logic [15:0]        cycle_count
`ifdef BOOT_SEQ_CHECKSUM_EN
  ,
  output logic [31:0]        checksum
`endif
);

  localparam int unsigned       CW       = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CW-1:0]     CLR_LAST = CW'(CLEAR_CYCLES - 1);
  localparam int unsigned       AW       = $clog2(MAX_WORDS + 1);
  localparam logic [AW-1:0]     ACC_MAX  = AW'(MAX_WORDS);
  localparam logic [AW-1:0]     ACC_LAST = AW'(MAX_WORDS - 1);
  localparam logic [PC_SIZE-1:0] STEP    = PC_SIZE'(ADDR_STEP);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_SETTLE, S_RUN, S_DONE
  } state_t;

  state_t               state, state_next;
  logic [CW-1:0]        clear_cnt;
  logic [AW-1:0]        accept_cnt;
  logic                 we_q;
  logic [PC_SIZE-1:0]   addr_q;
  logic [31:0]          data_q;
  logic                 error_q;
  logic [PC_SIZE:0]     word_cnt_q;
  logic [15:0]          cyc_q;
  logic [31:0]          csum_q;

  logic transfer;
  logic commit;
  logic boot_start;

  // load_ready is already gated by abort, so an accept can never race an abort
  assign transfer   = load_valid & load_ready;
  // A registered write pending during abort is dropped, not committed
  assign commit     = we_q & ~abort;
  assign boot_start = start & ~abort & ((state == S_IDLE) | (state == S_DONE));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (start) state_next = S_CLEAR;
        S_CLEAR:  if (clear_cnt == CLR_LAST) state_next = S_LOAD;
        S_LOAD: begin
          if (transfer) begin
            if (load_last)                    state_next = S_SETTLE;
            else if (accept_cnt == ACC_LAST)  state_next = S_DONE;
          end
        end
        S_SETTLE: state_next = S_RUN;
        S_RUN: begin
          if ((run_limit != 16'd0) && (cyc_q == 16'(run_limit - 16'd1)))
            state_next = S_DONE;
        end
        S_DONE:   if (start) state_next = S_CLEAR;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    load_ready  = (state == S_LOAD) && (accept_cnt < ACC_MAX) && !abort;
    core_reset  = (state != S_RUN) || abort;
    imem_reset  = (state == S_CLEAR) && !abort;
    imem_we     = commit;
    imem_addr   = addr_q;
    imem_data   = data_q;
    busy        = (state != S_IDLE) && (state != S_DONE);
    done        = (state == S_DONE);
    error       = error_q;
    word_count  = word_cnt_q;
    cycle_count = cyc_q;
  end

`ifdef BOOT_SEQ_CHECKSUM_EN
  assign checksum = csum_q;
`endif

  // Datapath: write pipeline, counters and flags
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_cnt  <= '0;
      accept_cnt <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      error_q    <= 1'b0;
      word_cnt_q <= '0;
      cyc_q      <= '0;
      csum_q     <= '0;
    end else begin
      we_q <= transfer;
      if (transfer) data_q <= load_data;

      if (boot_start) begin
        clear_cnt  <= '0;
        accept_cnt <= '0;
        addr_q     <= '0;
        error_q    <= 1'b0;
        word_cnt_q <= '0;
        cyc_q      <= '0;
        csum_q     <= '0;
      end else begin
        // Address and word count advance when the write is issued, so an
        // aborted pending write leaves both untouched.
        if (commit) begin
          addr_q     <= addr_q + STEP;
          word_cnt_q <= word_cnt_q + (PC_SIZE+1)'(1);
        end
        if (transfer) begin
          accept_cnt <= accept_cnt + AW'(1);
          csum_q     <= {csum_q[30:0], csum_q[31]} ^ load_data;
          if (!load_last && (accept_cnt == ACC_LAST)) error_q <= 1'b1;
        end
        if (state == S_CLEAR) clear_cnt <= clear_cnt + CW'(1);
        if ((state == S_RUN) && !abort && (cyc_q != 16'hFFFF))
          cyc_q <= cyc_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_boot_sequencer.sv
// Directed testbench for riscv_boot_sequencer.
//   The bench instantiates two copies of the sequencer:
//     dut    default parameters
//     dut_b  MAX_WORDS = 4, used for the overflow case
//   Both copies share the same inputs.
//   Timing:
//     - Inputs change 1 time unit after each rising edge.
//     - Outputs are sampled on the falling edge.
module tb_riscv_boot_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, abort;
  logic [15:0] run_limit;
  logic        load_valid, load_last;
  logic [31:0] load_data;

  logic        load_ready, core_reset, imem_reset, imem_we, busy, done, error;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [10:0] word_count;
  logic [15:0] cycle_count;

  logic        b_load_ready, b_core_reset, b_imem_reset, b_imem_we, b_busy, b_done, b_error;
  logic [9:0]  b_imem_addr;
  logic [31:0] b_imem_data;
  logic [10:0] b_word_count;
  logic [15:0] b_cycle_count;
`ifdef BOOT_SEQ_CHECKSUM_EN
  logic [31:0] checksum, b_checksum;
`endif

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int unsigned clr_cycles   = 0;
  int unsigned run_cycles   = 0;
  int unsigned b_run_cycles = 0;

  always #5 clock = ~clock;

  riscv_boot_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .run_limit(run_limit), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .core_reset(core_reset),
    .imem_reset(imem_reset), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_data(imem_data), .busy(busy), .done(done), .error(error),
    .word_count(word_count), .cycle_count(cycle_count)
`ifdef BOOT_SEQ_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  riscv_boot_sequencer #(.MAX_WORDS(4)) dut_b (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .run_limit(run_limit), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(b_load_ready), .core_reset(b_core_reset),
    .imem_reset(b_imem_reset), .imem_we(b_imem_we), .imem_addr(b_imem_addr),
    .imem_data(b_imem_data), .busy(b_busy), .done(b_done), .error(b_error),
    .word_count(b_word_count), .cycle_count(b_cycle_count)
`ifdef BOOT_SEQ_CHECKSUM_EN
    , .checksum(b_checksum)
`endif
  );

  // Record every write pulse and count reset phases of the default instance
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      log_addr.push_back(32'(imem_addr));
      log_data.push_back(imem_data);
    end
    if (imem_reset === 1'b1) clr_cycles++;
    if (core_reset === 1'b0) run_cycles++;
    if (b_core_reset === 1'b0) b_run_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] la(input int unsigned i);
    return (i < log_addr.size()) ? log_addr[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] ld(input int unsigned i);
    return (i < log_data.size()) ? log_data[i] : 32'hxxxxxxxx;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    clr_cycles = 0;
    run_cycles = 0;
  endtask

  task automatic pulse_start(input logic [15:0] lim);
    run_limit = lim;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one word, wait (bounded) for load_ready, then leave after the accepting edge
  task automatic send(input logic [31:0] d, input logic last, input int unsigned gap);
    int unsigned t = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(negedge clock);
    while (!load_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    check("ready_wait", 32'(load_ready), 32'd1);
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    repeat (gap) step();
  endtask

  task automatic wait_done();
    int unsigned t = 0;
    @(negedge clock);
    while (!done && t < 200) begin
      @(negedge clock);
      t++;
    end
    check("done_wait", 32'(done), 32'd1);
  endtask

  task automatic wait_run();
    int unsigned t = 0;
    @(negedge clock);
    while (core_reset && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("run_wait", 32'(core_reset), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; run_limit = '0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state and idle
    @(negedge clock);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_ready",      32'(load_ready), 32'd0);
    check("rst_error",      32'(error),      32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    repeat (5) @(negedge clock);
    check("idle_no_we",     log_addr.size(), 32'd0);
    check("idle_core_reset", 32'(core_reset), 32'd1);

    // Basic 3-word boot, run_limit=10
    step();
    clear_logs();
    pulse_start(16'd10);
    send(32'h00000013, 1'b0, 0);
    send(32'h00100093, 1'b0, 0);
    send(32'h00208133, 1'b1, 0);
    wait_done();
    check("clr_cycles",  clr_cycles,      32'd2);
    check("we_count3",   log_addr.size(), 32'd3);
    check("addr0",       la(0), 32'd0);
    check("addr1",       la(1), 32'd4);
    check("addr2",       la(2), 32'd8);
    check("data0",       ld(0), 32'h00000013);
    check("data1",       ld(1), 32'h00100093);
    check("data2",       ld(2), 32'h00208133);
    check("word_count3", 32'(word_count),  32'd3);
    check("run_cycles",  run_cycles,       32'd10);
    check("cycle_count", 32'(cycle_count), 32'd10);
    check("done_core_reset", 32'(core_reset), 32'd1);
    check("done_busy",   32'(busy),  32'd0);
    check("done_error",  32'(error), 32'd0);

    // Gapped valid, 4 words, restart from DONE
    step();
    clear_logs();
    pulse_start(16'd3);
    send(32'h11111111, 1'b0, 1);
    send(32'h22222222, 1'b0, 1);
    send(32'h33333333, 1'b0, 1);
    send(32'h44444444, 1'b1, 1);
    wait_done();
    check("gap_we_count", log_addr.size(), 32'd4);
    check("gap_addr0", la(0), 32'd0);
    check("gap_addr1", la(1), 32'd4);
    check("gap_addr2", la(2), 32'd8);
    check("gap_addr3", la(3), 32'd12);
    check("gap_data3", ld(3), 32'h44444444);
    check("gap_word_count", 32'(word_count),  32'd4);
    check("gap_cycle_count", 32'(cycle_count), 32'd3);

    // Abort mid-LOAD after 2 words: the second write is still pending and is dropped
    step();
    clear_logs();
    pulse_start(16'd0);
    send(32'hAAAA0001, 1'b0, 0);
    send(32'hAAAA0002, 1'b0, 0);
    abort = 1'b1;
    @(negedge clock);
    check("abort_we",         32'(imem_we),    32'd0);
    check("abort_core_reset", 32'(core_reset), 32'd1);
    check("abort_imem_reset", 32'(imem_reset), 32'd0);
    step();
    abort = 1'b0;
    @(negedge clock);
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_done", 32'(done), 32'd0);
    repeat (3) @(negedge clock);
    check("abort_we_count",   log_addr.size(), 32'd1);
    check("abort_addr0",      la(0), 32'd0);
    check("abort_word_count", 32'(word_count), 32'd1);

    // Abort in RUN with run_limit=0
    step();
    clear_logs();
    pulse_start(16'd0);
    @(negedge clock);
    check("start_clr_word_count",  32'(word_count),  32'd0);
    check("start_clr_cycle_count", 32'(cycle_count), 32'd0);
    step();
    send(32'hBBBB0001, 1'b1, 0);
    wait_run();
    check("run_first_count", 32'(cycle_count), 32'd0);
    repeat (5) @(negedge clock);
    check("run_count5",  32'(cycle_count), 32'd5);
    check("run_busy",    32'(busy),        32'd1);
    step();
    abort = 1'b1;
    @(negedge clock);
    check("run_abort_core_reset", 32'(core_reset), 32'd1);
    step();
    abort = 1'b0;
    @(negedge clock);
    check("run_abort_idle", 32'(busy), 32'd0);
    check("run_abort_done", 32'(done), 32'd0);

    // Fresh boot after abort restarts at address 0
    step();
    clear_logs();
    pulse_start(16'd2);
    send(32'hDEADBEEF, 1'b1, 0);
    wait_done();
    check("restart_we_count",   log_addr.size(), 32'd1);
    check("restart_addr0",      la(0), 32'd0);
    check("restart_data0",      ld(0), 32'hDEADBEEF);
    check("restart_word_count", 32'(word_count),  32'd1);
    check("restart_cycles",     32'(cycle_count), 32'd2);

`ifdef BOOT_SEQ_CHECKSUM_EN
    // rotl(0)^1 = 1; rotl(1)^0x80000000 = 0x80000002
    step();
    pulse_start(16'd2);
    send(32'h00000001, 1'b0, 0);
    send(32'h80000000, 1'b1, 0);
    wait_done();
    check("checksum", checksum, 32'h80000002);
`endif

    // Overflow on the MAX_WORDS=4 instance
    step();
    begin
      int unsigned b_low_before;
      b_low_before = b_run_cycles;
      pulse_start(16'd5);
      send(32'hC0000001, 1'b0, 0);
      send(32'hC0000002, 1'b0, 0);
      send(32'hC0000003, 1'b0, 0);
      send(32'hC0000004, 1'b0, 0);
      @(negedge clock);
      check("ovf_ready",  32'(b_load_ready), 32'd0);
      check("ovf_error",  32'(b_error),      32'd1);
      check("ovf_done",   32'(b_done),       32'd1);
      check("ovf_last_we", 32'(b_imem_we),   32'd1);
      check("ovf_last_addr", 32'(b_imem_addr), 32'd12);
      load_valid = 1'b1;
      load_data  = 32'hC0000005;
      repeat (4) @(negedge clock);
      check("ovf_word_count", 32'(b_word_count), 32'd4);
      check("ovf_core_reset", 32'(b_core_reset), 32'd1);
      check("ovf_never_run",  b_run_cycles - b_low_before, 32'd0);
      check("ovf_hold_done",  32'(b_done),  32'd1);
      check("ovf_hold_error", 32'(b_error), 32'd1);
      check("big_no_error",   32'(error),   32'd0);
      load_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
